// File: rtl/mem_access_ctrl_if.sv
// Data-memory port between the access controller (master) and the memory (slave).
// The controller drives the request side; the memory returns ack and read data.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Turns the EX/MEM MemRead/MemWrite controls into a req/ack data-memory access,
// stalling the pipeline until completion and flagging misaligned or timed-out accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic [1:0]          MemWrite,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  output logic [31:0]         rdata,
  output logic                rdata_valid,
  output logic                misalign,
  output logic                timeout_err,
  mem_access_ctrl_if.master   mem
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST_CNT  =
    CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic        is_write;
  logic        access;
  logic        aligned;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  logic        launch;
  logic        reject;
  logic        ack_hit;
  logic        timeout_hit;

  // Access decode: a store of any size takes precedence over a simultaneous load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and a latch cannot be inferred.
    is_write = (MemWrite != 2'b00);
    access   = MemRead | is_write;
    aligned  = 1'b1;
    wstrb_d  = 4'b0000;
    wdata_d  = wdata;
    case (MemWrite)
      2'b01: begin
        wstrb_d = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b10: begin
        aligned = ~addr[0];
        wstrb_d = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      2'b11: begin
        aligned = (addr[1:0] == 2'b00);
        wstrb_d = 4'b1111;
      end
      default: begin
        aligned = (addr[1:0] == 2'b00);
      end
    endcase
  end

  // Next state and stall. Stall drops on the ack or timeout cycle so the
  // pipeline advances on the same edge the access retires.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    launch      = 1'b0;
    reject      = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall   = 1'b1;
            launch  = 1'b1;
            state_d = REQ;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          ack_hit = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT_EN && (cnt_q == LAST_CNT)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= '0;
      mem.mem_wdata <= '0;
      rdata         <= '0;
      rdata_valid   <= 1'b0;
      misalign      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_valid <= 1'b0;
      misalign    <= reject;
      timeout_err <= timeout_hit;

      if (launch) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= is_write;
        mem.mem_addr  <= {addr[31:2], 2'b00};
        mem.mem_wstrb <= wstrb_d;
        mem.mem_wdata <= wdata_d;
        cnt_q         <= '0;
      end

      if (state_q == REQ && !ack_hit && !timeout_hit) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (ack_hit || timeout_hit) begin
        mem.mem_req <= 1'b0;
      end

      if (ack_hit && !mem.mem_we) begin
        rdata       <= mem.mem_rdata;
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected memory transactions and load data
// are queued when stimulus is driven and popped when the DUT presents them.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        timeout_err;

  mem_access_ctrl_if mif ();

  mem_access_ctrl #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .timeout_err (timeout_err),
    .mem         (mif)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one EX/MEM access, plays the memory side, and returns how many cycles
  // mem_req and stall were high. ack_at = 0 means the memory never answers.
  task automatic run_access(
    input  string       name,
    input  logic        rd,
    input  logic [1:0]  wr,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  bit          exp_req,
    input  logic [3:0]  exp_strb,
    input  logic [31:0] exp_wd,
    input  int          ack_at,
    input  logic [31:0] rdat,
    output int          req_cycles,
    output int          stall_cycles
  );
    txn_t t;
    txn_t cur;
    bit   done;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = wd;
    if (exp_req) begin
      t.we    = (wr != 2'b00);
      t.addr  = {a[31:2], 2'b00};
      t.wstrb = exp_strb;
      t.wdata = exp_wd;
      exp_q.push_back(t);
      if (!t.we && ack_at != 0) rd_q.push_back(rdat);
    end
    req_cycles   = 0;
    stall_cycles = 0;
    done         = 1'b0;
    #1;
    if (stall === 1'b1) stall_cycles++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req !== 1'b1) begin
        done = 1'b1;
        break;
      end
      req_cycles++;
      if (req_cycles == 1) begin
        if (exp_q.size() == 0) check({name, " unexpected_req"}, 32'(mif.mem_req), 32'd0);
        else cur = exp_q.pop_front();
      end
      check({name, " mem_we"},    32'(mif.mem_we),    32'(cur.we));
      check({name, " mem_addr"},  mif.mem_addr,       cur.addr);
      check({name, " mem_wstrb"}, 32'(mif.mem_wstrb), 32'(cur.wstrb));
      if (cur.we) check({name, " mem_wdata"}, mif.mem_wdata, cur.wdata);
      if (req_cycles == ack_at) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rdat;
      end
      #1;
      if (stall === 1'b1) stall_cycles++;
    end
    if (!done) check({name, " req_budget"}, 32'(mif.mem_req), 32'd0);
    MemRead  = 1'b0;
    MemWrite = 2'b00;
  endtask

  int rq, st;

  initial begin
    rst           = 1'b1;
    MemRead       = 1'b0;
    MemWrite      = 2'b00;
    addr          = '0;
    wdata         = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    // Reset state, with a stray ack that must be ignored.
    tick();
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    tick();
    check("rst mem_req",     32'(mif.mem_req),   32'd0);
    check("rst mem_addr",    mif.mem_addr,       32'd0);
    check("rst mem_wstrb",   32'(mif.mem_wstrb), 32'd0);
    check("rst rdata",       rdata,              32'd0);
    check("rst rdata_valid", 32'(rdata_valid),   32'd0);
    check("rst stall",       32'(stall),         32'd0);
    rst = 1'b0;
    tick();

    // Word store, acked on the third REQ cycle. Stall covers the launch cycle
    // and the two un-acked REQ cycles, dropping in the ack cycle.
    run_access("word_st", 1'b0, 2'b11, 32'h100, 32'hDEADBEEF, 1'b1, 4'b1111,
               32'hDEADBEEF, 3, 32'h0, rq, st);
    check("word_st req_cycles",   32'(rq), 32'd3);
    check("word_st stall_cycles", 32'(st), 32'd3);
    check("word_st no_rvalid",    32'(rdata_valid), 32'd0);

    // Byte then half store back-to-back: the second launches right after the ack.
    run_access("byte_st", 1'b0, 2'b01, 32'h103, 32'h000000A5, 1'b1, 4'b1000,
               32'hA5A5A5A5, 1, 32'h0, rq, st);
    check("byte_st req_cycles", 32'(rq), 32'd1);
    run_access("half_st", 1'b0, 2'b10, 32'h102, 32'h0000BEEF, 1'b1, 4'b1100,
               32'hBEEFBEEF, 2, 32'h0, rq, st);
    check("half_st req_cycles", 32'(rq), 32'd2);
    run_access("half_lo", 1'b0, 2'b10, 32'h100, 32'h00001234, 1'b1, 4'b0011,
               32'h12341234, 1, 32'h0, rq, st);
    run_access("byte_1",  1'b0, 2'b01, 32'h101, 32'h0000003C, 1'b1, 4'b0010,
               32'h3C3C3C3C, 1, 32'h0, rq, st);

    // Load with read data returned on the ack.
    run_access("load", 1'b1, 2'b00, 32'h200, 32'h0, 1'b1, 4'b0000,
               32'h0, 2, 32'h12345678, rq, st);
    check("load rdata_valid", 32'(rdata_valid), 32'd1);
    if (rd_q.size() != 0) check("load rdata", rdata, rd_q.pop_front());
    tick();
    check("load rvalid_pulse", 32'(rdata_valid), 32'd0);
    check("load rdata_hold",   rdata,            32'h12345678);

    // Misaligned half store and load: rejected without a request or a stall.
    run_access("half_mis", 1'b0, 2'b10, 32'h101, 32'h0, 1'b0, 4'b0000,
               32'h0, 0, 32'h0, rq, st);
    check("half_mis misalign",   32'(misalign), 32'd1);
    check("half_mis req_cycles", 32'(rq),       32'd0);
    check("half_mis stall",      32'(st),       32'd0);
    tick();
    check("half_mis pulse", 32'(misalign), 32'd0);
    run_access("load_mis", 1'b1, 2'b00, 32'h202, 32'h0, 1'b0, 4'b0000,
               32'h0, 0, 32'h0, rq, st);
    check("load_mis misalign",   32'(misalign), 32'd1);
    check("load_mis req_cycles", 32'(rq),       32'd0);
    tick();

    // No ack: four REQ cycles, stall released in the last, then a timeout pulse.
    run_access("tmo", 1'b0, 2'b11, 32'h300, 32'h11112222, 1'b1, 4'b1111,
               32'h11112222, 0, 32'h0, rq, st);
    check("tmo req_cycles",   32'(rq), 32'd4);
    check("tmo stall_cycles", 32'(st), 32'd4);
    check("tmo timeout_err",  32'(timeout_err), 32'd1);
    tick();
    check("tmo pulse",   32'(timeout_err), 32'd0);
    check("tmo mem_req", 32'(mif.mem_req), 32'd0);

    // Ack on the timeout cycle wins.
    run_access("ack_last", 1'b1, 2'b00, 32'h304, 32'h0, 1'b1, 4'b0000,
               32'h0, 4, 32'hA0B0C0D0, rq, st);
    check("ack_last req_cycles",  32'(rq), 32'd4);
    check("ack_last timeout_err", 32'(timeout_err), 32'd0);
    check("ack_last rdata_valid", 32'(rdata_valid), 32'd1);
    if (rd_q.size() != 0) check("ack_last rdata", rdata, rd_q.pop_front());
    tick();

    // Simultaneous load and word store: the store is issued, no load data.
    run_access("rd_wr", 1'b1, 2'b11, 32'h400, 32'hCAFEF00D, 1'b1, 4'b1111,
               32'hCAFEF00D, 1, 32'h55555555, rq, st);
    check("rd_wr req_cycles",  32'(rq), 32'd1);
    check("rd_wr no_rvalid",   32'(rdata_valid), 32'd0);
    check("rd_wr rdata_hold",  rdata, 32'hA0B0C0D0);
    tick();

    // Reset on the second REQ cycle discards the access; a late ack is ignored.
    MemRead = 1'b1;
    addr    = 32'h500;
    tick();
    check("rst_mid req1", 32'(mif.mem_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    MemRead = 1'b0;
    check("rst_mid mem_req",     32'(mif.mem_req),   32'd0);
    check("rst_mid mem_addr",    mif.mem_addr,       32'd0);
    check("rst_mid mem_wdata",   mif.mem_wdata,      32'd0);
    check("rst_mid rdata",       rdata,              32'd0);
    check("rst_mid timeout_err", 32'(timeout_err),   32'd0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hBAD0BAD0;
    tick();
    mif.mem_ack = 1'b0;
    tick();
    check("rst_mid late_ack rvalid", 32'(rdata_valid), 32'd0);
    check("rst_mid late_ack rdata",  rdata,            32'd0);
    check("rst_mid stall",           32'(stall),       32'd0);

    check("sb txn_empty",  32'(exp_q.size()), 32'd0);
    check("sb rdata_empty", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
